// File: rtl/banco_registros.sv
// banco_registros: 32 x 32-bit MIPS register file with two combinational
// read ports, one write-back port, a same-cycle write-through bypass on the
// read ports, an unbypassed debug port and a committed-write counter.
// Register 0 has no storage and reads as zero everywhere.
module banco_registros #(
   parameter int ANCHO = 32,
   parameter int NREG  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [$clog2(NREG)-1:0] ReadReg1,
   input  logic [$clog2(NREG)-1:0] ReadReg2,
   input  logic [$clog2(NREG)-1:0] WriteReg,
   input  logic [ANCHO-1:0]        WriteData,
   input  logic                    RegWrite,
   input  logic [$clog2(NREG)-1:0] DbgReg,
   output logic [ANCHO-1:0]        ReadData1,
   output logic [ANCHO-1:0]        ReadData2,
   output logic [ANCHO-1:0]        DbgData,
   output logic [15:0]             WrCount
);

   localparam int AW = $clog2(NREG);

   // Storage starts at index 1: register 0 is a constant, not a flop.
   logic [ANCHO-1:0] regs_q [1:NREG-1];
   logic [ANCHO-1:0] regs_d [1:NREG-1];
   logic [15:0]      wr_count_q;
   logic [15:0]      wr_count_d;
   logic             we_s;
   logic [ANCHO-1:0] rd1_s;
   logic [ANCHO-1:0] rd2_s;
   logic [ANCHO-1:0] dbg_s;

   // Qualified write enable; an unknown address cannot leak through when RegWrite is low.
   always_comb begin
      we_s = 1'b0;
      if ((RegWrite == 1'b1) && (WriteReg != {AW{1'b0}})) begin
         we_s = 1'b1;
      end else begin
         we_s = 1'b0;
      end
   end

   // Next-state for storage and the committed-write counter (wraps naturally at 16 bits).
   always_comb begin
      regs_d     = regs_q;
      wr_count_d = wr_count_q;
      if (we_s) begin
         for (int i = 1; i < NREG; i++) begin
            regs_d[i] = (WriteReg == AW'(i)) ? WriteData : regs_q[i];
         end
         wr_count_d = wr_count_q + 16'd1;
      end else begin
         regs_d     = regs_q;
         wr_count_d = wr_count_q;
      end
   end

   // State registers with asynchronous clear of the whole file and the counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= {ANCHO{1'b0}};
         end
         wr_count_q <= 16'd0;
      end else begin
         regs_q     <= regs_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Raw storage lookup for the three read addresses; address 0 matches nothing and stays zero.
   always_comb begin
      rd1_s = {ANCHO{1'b0}};
      rd2_s = {ANCHO{1'b0}};
      dbg_s = {ANCHO{1'b0}};
      for (int i = 1; i < NREG; i++) begin
         rd1_s = (ReadReg1 == AW'(i)) ? regs_q[i] : rd1_s;
         rd2_s = (ReadReg2 == AW'(i)) ? regs_q[i] : rd2_s;
         dbg_s = (DbgReg   == AW'(i)) ? regs_q[i] : dbg_s;
      end
   end

   // Output stage: write-through bypass on the read ports, forced zero while in reset.
   always_comb begin
      ReadData1 = {ANCHO{1'b0}};
      ReadData2 = {ANCHO{1'b0}};
      DbgData   = {ANCHO{1'b0}};
      if (rst_n) begin
         ReadData1 = (we_s && (WriteReg == ReadReg1)) ? WriteData : rd1_s;
         ReadData2 = (we_s && (WriteReg == ReadReg2)) ? WriteData : rd2_s;
         DbgData   = dbg_s;
      end else begin
         ReadData1 = {ANCHO{1'b0}};
         ReadData2 = {ANCHO{1'b0}};
         DbgData   = {ANCHO{1'b0}};
      end
   end

   assign WrCount = wr_count_q;

endmodule

// File: tb/tb_banco_registros.sv
// Scoreboard bench for banco_registros: stimulus pushes expected outputs
// from a plain array model, a negedge monitor pops and compares.
module tb_banco_registros;

   logic        clk;
   logic        rst_n;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        RegWrite;
   logic [4:0]  DbgReg;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [31:0] DbgData;
   logic [15:0] WrCount;

   banco_registros #(.ANCHO(32), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
      .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
      .DbgReg(DbgReg),
      .ReadData1(ReadData1), .ReadData2(ReadData2),
      .DbgData(DbgData), .WrCount(WrCount)
   );

   typedef struct {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] dbg;
      logic [15:0] cnt;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [0:31];
   logic [15:0] mdl_cnt;
   int          errors = 0;
   int          checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference: register a reads as the last value written to it, 0 for r0.
   function automatic logic [31:0] mdl_read(input logic [4:0] a, input bit rw,
                                            input logic [4:0] wr, input logic [31:0] wd,
                                            input bit byp);
      if (a == 5'd0) return 32'd0;
      if (byp && rw && (wr == a)) return wd;
      return mdl[a];
   endfunction

   task automatic mdl_clear();
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      mdl_cnt = 16'd0;
   endtask

   task automatic drive(input bit rw, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dr);
      RegWrite = rw; WriteReg = wr; WriteData = wd;
      ReadReg1 = r1; ReadReg2 = r2; DbgReg = dr;
   endtask

   task automatic advance(input bit rw, input logic [4:0] wr, input logic [31:0] wd);
      @(posedge clk);
      if (rst_n && rw && (wr != 5'd0)) begin
         mdl[wr] = wd;
         mdl_cnt = mdl_cnt + 16'd1;
      end
      #1;
   endtask

   // One cycle with model-derived expectations.
   task automatic step(input bit rw, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dr,
                       input string tag);
      exp_t e;
      drive(rw, wr, wd, r1, r2, dr);
      if (!rst_n) begin
         e.rd1 = 32'd0; e.rd2 = 32'd0; e.dbg = 32'd0; e.cnt = 16'd0;
      end else begin
         e.rd1 = mdl_read(r1, rw, wr, wd, 1'b1);
         e.rd2 = mdl_read(r2, rw, wr, wd, 1'b1);
         e.dbg = mdl_read(dr, rw, wr, wd, 1'b0);
         e.cnt = mdl_cnt;
      end
      e.tag = tag;
      sb.push_back(e);
      advance(rw, wr, wd);
   endtask

   // One cycle with literal expectations taken straight from the directed scenarios.
   task automatic stepx(input bit rw, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dr,
                        input logic [31:0] x1, input logic [31:0] x2, input logic [31:0] xd,
                        input logic [15:0] xc, input string tag);
      exp_t e;
      drive(rw, wr, wd, r1, r2, dr);
      e.rd1 = x1; e.rd2 = x2; e.dbg = xd; e.cnt = xc; e.tag = tag;
      sb.push_back(e);
      advance(rw, wr, wd);
   endtask

   // Monitor: compare DUT outputs mid-cycle against the oldest pending expectation.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks = checks + 4;
         if (ReadData1 !== e.rd1) begin
            errors++;
            $display("FAIL %s rd1: got %h want %h", e.tag, ReadData1, e.rd1);
         end
         if (ReadData2 !== e.rd2) begin
            errors++;
            $display("FAIL %s rd2: got %h want %h", e.tag, ReadData2, e.rd2);
         end
         if (DbgData !== e.dbg) begin
            errors++;
            $display("FAIL %s dbg: got %h want %h", e.tag, DbgData, e.dbg);
         end
         if (WrCount !== e.cnt) begin
            errors++;
            $display("FAIL %s cnt: got %h want %h", e.tag, WrCount, e.cnt);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] w;
      logic [4:0] a1;
      logic [4:0] a2;
      mdl_clear();
      rst_n = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);

      // Reset held two cycles; writes attempted meanwhile must be ignored.
      @(posedge clk); #1;
      step(1'b1, 5'd5, 32'h1111_1111, 5'd5, 5'd5, 5'd5, "rst_hold0");
      step(1'b1, 5'd6, 32'h2222_2222, 5'd6, 5'd6, 5'd6, "rst_hold1");
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i), "rst_scan");
      end

      // Write then read.
      stepx(1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 16'd0, "wr5");
      stepx(1'b1, 5'd31, 32'h1234_5678, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 16'd1, "wr31");
      stepx(1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 5'd5,
            32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 16'd2, "rd_5_31");

      // Same-cycle bypass on both ports, debug sees old value until the edge.
      stepx(1'b1, 5'd8, 32'h0000_0011, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 16'd2, "wr8");
      stepx(1'b1, 5'd8, 32'h0000_00AA, 5'd8, 5'd8, 5'd8,
            32'h0000_00AA, 32'h0000_00AA, 32'h0000_0011, 16'd3, "bypass");
      stepx(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'h0000_00AA, 16'd4, "post_byp");

      // Register 0 protection.
      stepx(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd8, 5'd0, 32'd0, 32'h0000_00AA, 32'd0, 16'd4, "r0_wr");
      stepx(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 16'd4, "r0_after");

      // Disabled write leaves reg3 intact and is not bypassed; unknowns are harmless.
      stepx(1'b1, 5'd3, 32'h0000_0007, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 16'd4, "wr3");
      stepx(1'b0, 5'd3, 32'h5555_5555, 5'd3, 5'd3, 5'd3,
            32'h0000_0007, 32'h0000_0007, 32'h0000_0007, 16'd5, "dis_wr");
      stepx(1'b0, 5'bxxxxx, 32'hxxxx_xxxx, 5'd3, 5'd5, 5'd3,
            32'h0000_0007, 32'hDEAD_BEEF, 32'h0000_0007, 16'd5, "x_safe");
      step(1'b0, 5'd0, 32'd0, 5'd3, 5'd31, 5'd8, "x_after");

      // Randomized traffic, read addresses often colliding with the write address.
      for (int n = 0; n < 1500; n++) begin
         w  = 5'($urandom_range(0, 31));
         a1 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? w : 5'($urandom_range(0, 31));
         step(1'($urandom_range(0, 1)), w, $urandom(), a1, a2,
              5'($urandom_range(0, 31)), "rand");
      end

      // Asynchronous reset between edges: outputs clear at once, writes ignored.
      rst_n = 1'b0;
      mdl_clear();
      stepx(1'b1, 5'd3, 32'h0000_0009, 5'd3, 5'd5, 5'd3, 32'd0, 32'd0, 32'd0, 16'd0, "async_rst");
      step(1'b1, 5'd4, 32'h0000_0004, 5'd4, 5'd3, 5'd4, "rst_wr_ign");
      #2 rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         step(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i), "post_rst");
      end

      // Drive the counter to 0xFFFF, then one more write must wrap it to zero.
      while (mdl_cnt != 16'hFFFF) begin
         w = 5'($urandom_range(1, 31));
         step(1'b1, w, $urandom(), w, 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), "fill");
      end
      stepx(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 16'hFFFF, "cnt_ffff");
      step(1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd0, 5'd7, "wrap_wr");
      stepx(1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 5'd7,
            32'hCAFE_F00D, 32'd0, 32'hCAFE_F00D, 16'h0000, "wrap");

      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/banco_registros.md
Name: banco_registros

Overview:
- 32 x 32-bit general-purpose register file for the 5-stage MIPS pipeline.
- Produces ReadData1/ReadData2 for the ID/EX stage; ReadData2 is the register operand that the ALU operand-B select chooses against the sign-extended immediate.
- Takes its single write port from the write-back stage.
- Provides a write-through bypass so that an instruction in ID sees a value being written back in the same cycle.

Parameters:
- ANCHO, 32, data width in bits.
- NREG, 32, number of registers; address width is log2(NREG) = 5.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- ReadReg1  input  5  rs address, read port 1.
- ReadReg2  input  5  rt address, read port 2.
- WriteReg  input  5  destination address from WB.
- WriteData  input  ANCHO  write-back value.
- RegWrite  input  1  write enable from WB.
- DbgReg  input  5  address for the debug/observation port.
- ReadData1  output  ANCHO  value of register ReadReg1.
- ReadData2  output  ANCHO  value of register ReadReg2.
- DbgData  output  ANCHO  value of register DbgReg (no bypass).
- WrCount  output  16  count of committed writes, for bench and debug.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all NREG registers and WrCount to 0, with no clock edge required.
  - While rst_n is low, all read outputs show 0.
  - Writes are ignored while rst_n is low.
  - Deasserting rst_n mid-cycle leaves the contents at 0; the first write can occur on the next rising edge.
- Write:
  - On the rising edge with rst_n high, RegWrite=1 and WriteReg!=0: reg[WriteReg] <= WriteData and WrCount <= WrCount+1.
  - Write latency is 1 cycle into storage.
  - WrCount wraps from 0xFFFF to 0x0000.
  - A write with RegWrite=1 and WriteReg=0 is discarded, and WrCount does not increment.
- Register 0:
  - Reads as 0 on all three ports under all conditions.
  - Never stored and never bypassed.
- Read ports 1 and 2:
  - Combinational, with 0-cycle latency from address change to data.
  - Bypass rule per port: if RegWrite=1, WriteReg!=0 and WriteReg==ReadRegN, then ReadDataN = WriteData (same cycle). Otherwise ReadDataN = reg[ReadRegN].
  - Both ports may address the same register and may both bypass simultaneously.
- Debug port: DbgData = reg[DbgReg], with no bypass; it shows the new value only after the write edge.
- Simultaneous read and write to the same address:
  - The read port returns the new value via bypass before the edge.
  - After the edge, storage holds the new value.
  - Result: consistent new-value semantics for the whole cycle.
- RegWrite=0: no state change, regardless of WriteReg or WriteData.
- X-safety: with RegWrite=0, unknown values on WriteReg or WriteData must not corrupt storage or WrCount.
- Storage elements: registers only, no inferred RAM with a read latency; all reads are asynchronous.

Test Plan:
1. Reset check: hold rst_n=0 for 2 cycles, release, read all 32 addresses on ReadData1/ReadData2/DbgData -> all 0x00000000; WrCount=0.
2. Write then read: write reg5=0xDEADBEEF and reg31=0x12345678 on consecutive edges, then ReadReg1=5 and ReadReg2=31 -> ReadData1=0xDEADBEEF, ReadData2=0x12345678, DbgData(DbgReg=5)=0xDEADBEEF, WrCount=2.
3. Same-cycle bypass: reg8 holds 0x00000011. Drive RegWrite=1, WriteReg=8, WriteData=0x000000AA, ReadReg1=ReadReg2=8 -> before the edge both read ports show 0x000000AA while DbgData(8) shows 0x00000011; after the edge DbgData=0x000000AA.
4. $zero protection: write 0xFFFFFFFF to reg0 with ReadReg1=0 in the same cycle -> ReadData1=0 before and after the edge; WrCount unchanged.
5. Disabled write: RegWrite=0, WriteReg=3, WriteData=0x55555555 -> reg3 keeps its prior value and ReadData shows no bypass. Then assert rst_n=0 asynchronously between clock edges after writing reg3=0x7 -> ReadData immediately 0 and WrCount=0.
6. Counter wrap: preload WrCount to 0xFFFF via 65535 writes (or a force), then one more valid write -> WrCount=0x0000 and the data is written correctly.
